// File: rtl/dma_xform_pipe.sv
// Streaming transform engine between the DMA read and write FIFOs.
// Lines flow read FIFO -> lane transform -> fixed-latency pipeline -> output FIFO -> write FIFO.
module dma_xform_pipe #(
  parameter int DATA_WIDTH  = 512,
  parameter int LANE_WIDTH  = 32,
  parameter int SIZE_WIDTH  = 43,
  parameter int PIPE_STAGES = 2,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  go,
  input  logic [SIZE_WIDTH-1:0] size,
  input  logic [1:0]            mode,
  input  logic [LANE_WIDTH-1:0] operand,
  output logic                  busy,
  output logic                  done,
  output logic [SIZE_WIDTH-1:0] lines_done,
  input  logic                  rd_empty,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_en,
  input  logic                  wr_full,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_en
);

  localparam int LANES = DATA_WIDTH / LANE_WIDTH;
  localparam int NBYTES = LANE_WIDTH / 8;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]            state_reg;
  logic [SIZE_WIDTH-1:0] size_reg;
  logic [1:0]            mode_reg;
  logic [LANE_WIDTH-1:0] operand_reg;
  logic [SIZE_WIDTH-1:0] rd_cnt_reg;
  logic [SIZE_WIDTH-1:0] wr_cnt_reg;
  logic [SIZE_WIDTH-1:0] wr_cnt_inc;

  logic [DATA_WIDTH-1:0] xform_data;
  logic                  arr_valid;
  logic [DATA_WIDTH-1:0] arr_data;
  logic [31:0]           inflight;
  logic [31:0]           occupancy;
  logic                  credit_ok;

  logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [PTR_W-1:0]      rd_ptr_reg;
  logic [CNT_W-1:0]      fifo_count_reg;
  logic                  fifo_empty;

  genvar gi, gj;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Lines already in the pipeline or FIFO each hold a reserved slot, so arrival never overflows.
  assign occupancy = 32'(fifo_count_reg) + inflight;
  assign credit_ok = occupancy < 32'(FIFO_DEPTH);
  assign rd_en     = (state_reg == S_RUN) && !rd_empty && (rd_cnt_reg < size_reg) && credit_ok;

  assign fifo_empty = (fifo_count_reg == '0);
  assign wr_en      = !fifo_empty && !wr_full;
  assign wr_data    = fifo_empty ? '0 : fifo_mem[rd_ptr_reg];
  assign wr_cnt_inc = wr_cnt_reg + 1'b1;

  assign busy       = (state_reg == S_RUN);
  assign done       = (state_reg == S_DONE);
  assign lines_done = wr_cnt_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= S_IDLE;
      size_reg    <= '0;
      mode_reg    <= '0;
      operand_reg <= '0;
      rd_cnt_reg  <= '0;
      wr_cnt_reg  <= '0;
    end else begin
      case (state_reg)
        S_IDLE, S_DONE: begin
          if (go) begin
            size_reg    <= size;
            mode_reg    <= mode;
            operand_reg <= operand;
            rd_cnt_reg  <= '0;
            wr_cnt_reg  <= '0;
            state_reg   <= (size == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (rd_en) rd_cnt_reg <= rd_cnt_reg + 1'b1;
          if (wr_en) begin
            wr_cnt_reg <= wr_cnt_inc;
            if (wr_cnt_inc == size_reg) state_reg <= S_DONE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  // The transform is applied combinationally on the read head; the registers only add latency.
  for (gi = 0; gi < LANES; gi++) begin : g_lane
    logic [LANE_WIDTH-1:0] lane_in;
    logic [LANE_WIDTH-1:0] lane_rev;
    logic [LANE_WIDTH-1:0] lane_out;
    assign lane_in = rd_data[gi*LANE_WIDTH +: LANE_WIDTH];
    for (gj = 0; gj < NBYTES; gj++) begin : g_byte
      assign lane_rev[gj*8 +: 8] = lane_in[(NBYTES-1-gj)*8 +: 8];
    end
    always_comb begin
      case (mode_reg)
        2'd1:    lane_out = lane_in + operand_reg;
        2'd2:    lane_out = lane_in ^ operand_reg;
        2'd3:    lane_out = lane_rev;
        default: lane_out = lane_in;
      endcase
    end
    assign xform_data[gi*LANE_WIDTH +: LANE_WIDTH] = lane_out;
  end

  if (PIPE_STAGES > 1) begin : g_pipe
    logic [DATA_WIDTH-1:0]  pipe_data [PIPE_STAGES-1];
    logic [PIPE_STAGES-2:0] pipe_valid;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        pipe_valid <= '0;
        for (int i = 0; i < PIPE_STAGES - 1; i++) pipe_data[i] <= '0;
      end else begin
        pipe_valid[0] <= rd_en;
        pipe_data[0]  <= xform_data;
        for (int i = 1; i < PIPE_STAGES - 1; i++) begin
          pipe_valid[i] <= pipe_valid[i-1];
          pipe_data[i]  <= pipe_data[i-1];
        end
      end
    end

    always_comb begin
      inflight = '0;
      for (int i = 0; i < PIPE_STAGES - 1; i++) inflight = inflight + {31'd0, pipe_valid[i]};
    end

    assign arr_valid = pipe_valid[PIPE_STAGES-2];
    assign arr_data  = pipe_data[PIPE_STAGES-2];
  end else begin : g_nopipe
    assign inflight  = '0;
    assign arr_valid = rd_en;
    assign arr_data  = xform_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      fifo_count_reg <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
    end else begin
      if (arr_valid) begin
        fifo_mem[wr_ptr_reg] <= arr_data;
        wr_ptr_reg           <= ptr_next(wr_ptr_reg);
      end
      if (wr_en) rd_ptr_reg <= ptr_next(rd_ptr_reg);
      case ({arr_valid, wr_en})
        2'b10:   fifo_count_reg <= fifo_count_reg + 1'b1;
        2'b01:   fifo_count_reg <= fifo_count_reg - 1'b1;
        default: fifo_count_reg <= fifo_count_reg;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_xform_pipe.sv
// Scoreboard bench for dma_xform_pipe: a read-FIFO model feeds lines, expected
// transformed lines are queued at stimulus time and popped on every wr_en.
module tb_dma_xform_pipe;
  localparam int DW = 512;
  localparam int LW = 32;
  localparam int SW = 43;
  localparam int PS = 2;
  localparam int FD = 8;

  typedef logic [DW-1:0] line_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          go = 1'b0;
  logic [SW-1:0] size = '0;
  logic [1:0]    mode = '0;
  logic [LW-1:0] operand = '0;
  logic          busy, done, rd_en, wr_en;
  logic [SW-1:0] lines_done;
  logic          rd_empty = 1'b1;
  line_t         rd_data = '0;
  logic          wr_full = 1'b0;
  line_t         wr_data;

  dma_xform_pipe #(
    .DATA_WIDTH(DW), .LANE_WIDTH(LW), .SIZE_WIDTH(SW), .PIPE_STAGES(PS), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst(rst), .go(go), .size(size), .mode(mode), .operand(operand),
    .busy(busy), .done(done), .lines_done(lines_done),
    .rd_empty(rd_empty), .rd_data(rd_data), .rd_en(rd_en),
    .wr_full(wr_full), .wr_data(wr_data), .wr_en(wr_en)
  );

  always #5 clk = ~clk;

  line_t src_q[$];
  line_t exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int n_rd = 0, n_wr = 0, cyc = 0, first_rd = -1, first_wr = -1, last_wr = 0, gaps = 0, done_cyc = 0;
  bit pop_pending = 0, done_prev = 0, done_seen = 0;
  bit hold_full = 0, rand_empty = 0, rand_full = 0;

  function automatic line_t rand_line();
    line_t r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic line_t model(line_t d, logic [1:0] m, logic [LW-1:0] op);
    line_t r;
    logic [31:0] l;
    for (int i = 0; i < DW / 32; i++) begin
      l = d[i*32 +: 32];
      case (m)
        2'd1:    l = l + op;
        2'd2:    l = l ^ op;
        2'd3:    l = {l[7:0], l[15:8], l[23:16], l[31:24]};
        default: l = l;
      endcase
      r[i*32 +: 32] = l;
    end
    return r;
  endfunction

  // Monitor: samples on the falling edge what the next rising edge will commit.
  always @(negedge clk) begin
    cyc++;
    if (rd_en) begin
      n_rd++;
      if (first_rd < 0) first_rd = cyc;
      pop_pending = 1;
      n_cmp++;
      if (rd_empty !== 1'b0) begin
        n_err++;
        $display("FAIL rd_en_while_empty: rd_empty=%0b with rd_en=1, required rd_empty=0", rd_empty);
      end
    end
    if (wr_en) begin : wr_chk
      line_t e;
      if (n_wr > 0 && cyc != last_wr + 1) gaps++;
      last_wr = cyc;
      n_wr++;
      if (first_wr < 0) first_wr = cyc;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL wr_unexpected: got %h, no line expected", wr_data);
      end else begin
        e = exp_q.pop_front();
        if (wr_data !== e) begin
          n_err++;
          $display("FAIL wr_data line %0d: got %h exp %h", n_wr, wr_data, e);
        end else begin
          $display("wr line %0d ok: %h", n_wr, wr_data);
        end
      end
    end
    if (done && !done_prev) begin
      done_seen = 1;
      done_cyc = cyc;
    end
    done_prev = done;
  end

  // Read-FIFO and write-FIFO model, updated just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (pop_pending) begin
      if (src_q.size() > 0) src_q.delete(0);
      pop_pending = 0;
    end
    rd_empty = (src_q.size() == 0) || (rand_empty && ($urandom_range(0, 2) == 0));
    rd_data  = (src_q.size() > 0) ? src_q[0] : '0;
    wr_full  = hold_full || (rand_full && ($urandom_range(0, 2) == 0));
  end

  task automatic push_line(input line_t d, input line_t e);
    src_q.push_back(d);
    exp_q.push_back(e);
  endtask

  task automatic start_job(input logic [SW-1:0] s, input logic [1:0] m, input logic [LW-1:0] op);
    @(posedge clk); #2;
    n_rd = 0; n_wr = 0; first_rd = -1; first_wr = -1; gaps = 0; done_seen = 0;
    go = 1'b1; size = s; mode = m; operand = op;
    @(posedge clk); #2;
    go = 1'b0; size = '0; mode = ~m; operand = ~op;
  endtask

  task automatic wait_done(input int limit, output bit ok);
    int k = 0;
    while (!done_seen && k < limit) begin
      @(negedge clk); #1;
      k++;
    end
    ok = done_seen;
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0b exp 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %0b exp 0", done); end
    n_cmp++; if (rd_en !== 1'b0) begin n_err++; $display("FAIL reset_rd_en: got %0b exp 0", rd_en); end
    n_cmp++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL reset_wr_en: got %0b exp 0", wr_en); end
    n_cmp++; if (lines_done !== '0) begin n_err++; $display("FAIL reset_lines_done: got %0d exp 0", lines_done); end
    n_cmp++; if (wr_data !== '0) begin n_err++; $display("FAIL reset_wr_data: got %h exp 0", wr_data); end
    $display("reset checked");
    @(posedge clk); #2;
    rst = 1'b1;
  endtask

  task automatic test_pass_through();
    line_t d;
    bit ok;
    for (int i = 0; i < 16; i++) begin
      d = rand_line();
      push_line(d, d);
    end
    start_job(16, 2'd0, '0);
    wait_done(200, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL pass_done_timeout: done=%0b exp 1", done); end
    n_cmp++; if (n_rd != 16) begin n_err++; $display("FAIL pass_rd_count: got %0d exp 16", n_rd); end
    n_cmp++; if (n_wr != 16) begin n_err++; $display("FAIL pass_wr_count: got %0d exp 16", n_wr); end
    n_cmp++; if (first_wr - first_rd != PS) begin n_err++; $display("FAIL pass_latency: got %0d exp %0d", first_wr - first_rd, PS); end
    n_cmp++; if (gaps != 0) begin n_err++; $display("FAIL pass_throughput: got %0d gaps exp 0", gaps); end
    n_cmp++; if (done_cyc != last_wr + 1) begin n_err++; $display("FAIL pass_done_timing: got cycle %0d exp %0d", done_cyc, last_wr + 1); end
    n_cmp++; if (lines_done !== SW'(16)) begin n_err++; $display("FAIL pass_lines_done: got %0d exp 16", lines_done); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL pass_busy: got %0b exp 0", busy); end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL pass_leftover: got %0d exp 0", exp_q.size()); end
  endtask

  task automatic test_add_xor();
    line_t allf, mixed, d;
    bit ok;
    allf = '1;
    mixed = {8{32'h00000000, 32'hFFFFFFFF}};
    push_line(allf, '0);
    push_line(mixed, {8{32'h00000001, 32'h00000000}});
    start_job(2, 2'd1, 32'h00000001);
    wait_done(100, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL add_done_timeout: done=%0b exp 1", done); end
    n_cmp++; if (lines_done !== SW'(2)) begin n_err++; $display("FAIL add_lines_done: got %0d exp 2", lines_done); end
    d = rand_line();
    push_line(allf, {16{32'h0000FFFF}});
    push_line(d, model(d, 2'd2, 32'hFFFF0000));
    start_job(2, 2'd2, 32'hFFFF0000);
    wait_done(100, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL xor_done_timeout: done=%0b exp 1", done); end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL xor_leftover: got %0d exp 0", exp_q.size()); end
  endtask

  task automatic test_byte_reverse();
    bit ok;
    push_line({16{32'h11223344}}, {16{32'h44332211}});
    start_job(1, 2'd3, '0);
    wait_done(100, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL rev_done_timeout: done=%0b exp 1", done); end
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL rev_done: got %0b exp 1", done); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rev_busy: got %0b exp 0", busy); end
    n_cmp++; if (n_wr != 1) begin n_err++; $display("FAIL rev_wr_count: got %0d exp 1", n_wr); end
  endtask

  task automatic test_back_pressure();
    line_t d;
    logic [LW-1:0] op;
    bit ok;
    hold_full = 1;
    op = $urandom;
    for (int i = 0; i < 32; i++) begin
      d = rand_line();
      push_line(d, model(d, 2'd2, op));
    end
    start_job(32, 2'd2, op);
    repeat (20) @(negedge clk);
    #1;
    n_cmp++; if (n_rd != FD) begin n_err++; $display("FAIL bp_rd_stop: got %0d exp %0d", n_rd, FD); end
    n_cmp++; if (n_wr != 0) begin n_err++; $display("FAIL bp_wr_held: got %0d exp 0", n_wr); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL bp_busy: got %0b exp 1", busy); end
    hold_full = 0;
    wait_done(500, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL bp_done_timeout: done=%0b exp 1", done); end
    n_cmp++; if (n_rd != 32) begin n_err++; $display("FAIL bp_rd_count: got %0d exp 32", n_rd); end
    n_cmp++; if (n_wr != 32) begin n_err++; $display("FAIL bp_wr_count: got %0d exp 32", n_wr); end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL bp_leftover: got %0d exp 0", exp_q.size()); end

    rand_empty = 1;
    rand_full = 1;
    op = $urandom;
    for (int i = 0; i < 32; i++) begin
      d = rand_line();
      push_line(d, model(d, 2'd1, op));
    end
    start_job(32, 2'd1, op);
    wait_done(2000, ok);
    rand_empty = 0;
    rand_full = 0;
    n_cmp++; if (!ok) begin n_err++; $display("FAIL rnd_done_timeout: done=%0b exp 1", done); end
    n_cmp++; if (n_wr != 32) begin n_err++; $display("FAIL rnd_wr_count: got %0d exp 32", n_wr); end
    n_cmp++; if (lines_done !== SW'(32)) begin n_err++; $display("FAIL rnd_lines_done: got %0d exp 32", lines_done); end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL rnd_leftover: got %0d exp 0", exp_q.size()); end
  endtask

  task automatic test_size_zero();
    start_job('0, 2'd0, '0);
    #1;
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL zero_done: got %0b exp 1", done); end
    n_cmp++; if (lines_done !== '0) begin n_err++; $display("FAIL zero_lines_done: got %0d exp 0", lines_done); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL zero_busy: got %0b exp 0", busy); end
    repeat (5) @(negedge clk);
    #1;
    n_cmp++; if (n_rd != 0 || n_wr != 0) begin n_err++; $display("FAIL zero_traffic: got rd=%0d wr=%0d exp 0/0", n_rd, n_wr); end
  endtask

  task automatic test_go_during_run();
    line_t d;
    bit ok;
    hold_full = 1;
    for (int i = 0; i < 10; i++) begin
      d = rand_line();
      push_line(d, d);
    end
    start_job(10, 2'd0, '0);
    repeat (3) @(posedge clk);
    #2;
    go = 1'b1; size = 3; mode = 2'd3; operand = 32'h12345678;
    @(posedge clk); #2;
    go = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL run_go_busy: got %0b exp 1", busy); end
    hold_full = 0;
    wait_done(300, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL run_go_timeout: done=%0b exp 1", done); end
    n_cmp++; if (n_wr != 10) begin n_err++; $display("FAIL run_go_wr_count: got %0d exp 10", n_wr); end
    n_cmp++; if (lines_done !== SW'(10)) begin n_err++; $display("FAIL run_go_lines_done: got %0d exp 10", lines_done); end
  endtask

  task automatic test_reset_mid();
    line_t d;
    logic [LW-1:0] op;
    bit ok;
    int k;
    for (int i = 0; i < 10; i++) begin
      d = rand_line();
      push_line(d, d);
    end
    start_job(10, 2'd0, '0);
    k = 0;
    while (n_wr < 5 && k < 100) begin
      @(negedge clk); #1;
      k++;
    end
    n_cmp++; if (n_wr != 5) begin n_err++; $display("FAIL mid_reach5: got %0d exp 5", n_wr); end
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_rst_busy: got %0b exp 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL mid_rst_done: got %0b exp 0", done); end
    n_cmp++; if (rd_en !== 1'b0) begin n_err++; $display("FAIL mid_rst_rd_en: got %0b exp 0", rd_en); end
    n_cmp++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL mid_rst_wr_en: got %0b exp 0", wr_en); end
    n_cmp++; if (wr_data !== '0) begin n_err++; $display("FAIL mid_rst_wr_data: got %h exp 0", wr_data); end
    n_cmp++; if (lines_done !== '0) begin n_err++; $display("FAIL mid_rst_lines_done: got %0d exp 0", lines_done); end
    src_q.delete();
    exp_q.delete();
    pop_pending = 0;
    @(posedge clk); #2;
    rst = 1'b1;
    op = $urandom;
    for (int i = 0; i < 3; i++) begin
      d = rand_line();
      push_line(d, model(d, 2'd1, op));
    end
    start_job(3, 2'd1, op);
    wait_done(100, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL mid_new_timeout: done=%0b exp 1", done); end
    n_cmp++; if (n_rd != 3 || n_wr != 3) begin n_err++; $display("FAIL mid_new_counts: got rd=%0d wr=%0d exp 3/3", n_rd, n_wr); end
    n_cmp++; if (lines_done !== SW'(3)) begin n_err++; $display("FAIL mid_new_lines_done: got %0d exp 3", lines_done); end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL mid_new_leftover: got %0d exp 0", exp_q.size()); end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_pass_through();
    test_add_xor();
    test_byte_reverse();
    test_back_pressure();
    test_size_zero();
    test_go_during_run();
    test_reset_mid();
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dma_xform_pipe.md
Name: dma_xform_pipe

Overview:
- Parametrised streaming engine between the DMA read channel and the DMA write channel.
- Replaces direct loopback wiring. Pulls `size` cache lines from the read FIFO and applies a lane-wise transform (pass, add, xor, byte-reverse) through a PIPE_STAGES-deep pipeline.
- Buffers results in an internal output FIFO and pushes them to the write FIFO.
- A credit scheme guarantees that no line is dropped when the write side back-pressures.

Parameters:
- DATA_WIDTH, 512: cache-line width in bits; must be a multiple of LANE_WIDTH.
- LANE_WIDTH, 32: transform lane width in bits; multiple of 8.
- SIZE_WIDTH, 43: width of the line count (DMA clAddr width + 1).
- PIPE_STAGES, 2: transform pipeline latency in cycles; must be ≥1.
- FIFO_DEPTH, 8: output buffer entries; ≥1. Full throughput requires FIFO_DEPTH ≥ PIPE_STAGES+1.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- go  in  1  single-cycle start pulse; sampled in IDLE or DONE.
- size  in  SIZE_WIDTH  number of cache lines to transfer; latched on go.
- mode  in  2  0=pass, 1=add operand, 2=xor operand, 3=byte-reverse per lane; latched on go.
- operand  in  LANE_WIDTH  lane operand for modes 1/2; latched on go.
- busy  out  1  high in RUN.
- done  out  1  high in DONE; held until the next accepted go.
- lines_done  out  SIZE_WIDTH  count of lines written this job.
- rd_empty  in  1  DMA read FIFO empty.
- rd_data  in  DATA_WIDTH  DMA read FIFO head (show-ahead).
- rd_en  out  1  pop the read FIFO.
- wr_full  in  1  DMA write FIFO full.
- wr_data  out  DATA_WIDTH  line to write.
- wr_en  out  1  push to the write FIFO.

Behaviour:
- Reset (rst=0, async):
  - State goes to IDLE.
  - busy, done, rd_en, wr_en are 0.
  - lines_done is 0 and wr_data is 0.
  - All counters, pipeline valid bits and the output FIFO are cleared.
  - Reset mid-job aborts the job; in-flight data is discarded.
- FSM IDLE / RUN / DONE:
  - IDLE, go=1, size≠0 → RUN. size, mode and operand are latched; rd_cnt, wr_cnt and lines_done are cleared.
  - IDLE or DONE, go=1, size=0 → DONE on the next cycle with lines_done=0.
  - RUN → DONE in the cycle after the write that makes wr_cnt equal the latched size.
  - DONE, go=1 → restarts exactly as from IDLE (done drops on the following cycle).
  - go in RUN is ignored. Latched values are unaffected by input changes during RUN.
- Credit accounting:
  - credits = FIFO_DEPTH − fifo_count − inflight, where inflight = number of valid pipeline stages.
  - rd_en = RUN ∧ ¬rd_empty ∧ (rd_cnt < size) ∧ (credits > 0).
  - rd_en is combinational and never asserts when rd_empty=1.
  - Each rd_en increments rd_cnt and injects rd_data with valid=1 into stage 0.
- Pipeline:
  - Data advances every cycle; there is no stall.
  - The transformed line reaches the output FIFO PIPE_STAGES cycles after its rd_en.
  - The credit scheme guarantees that FIFO space exists on arrival.
- Transform, per lane i (lanes of LANE_WIDTH, lane 0 = LSBs):
  - mode 1: lane + operand, modulo 2^LANE_WIDTH; carry is discarded, no cross-lane carry.
  - mode 2: lane ^ operand.
  - mode 3: reverse the byte order within the lane.
  - mode 0: identity.
- Output FIFO:
  - Show-ahead; wr_data = FIFO head, or 0 when empty.
  - wr_en = ¬fifo_empty ∧ ¬wr_full, combinational.
  - Each wr_en pops the head and increments wr_cnt and lines_done.
  - Simultaneous arrival and pop in the same cycle: fifo_count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Ordering and completeness:
  - Lines are written in exactly the order they are read. No duplication, no loss.
  - Exactly `size` rd_en and `size` wr_en pulses occur per job.
- Widths: counters are SIZE_WIDTH bits. The comparison rd_cnt < size is unsigned, so the maximum size 2^SIZE_WIDTH−1 is supported.

Test Plan:
- Pass-through streaming: size=16, mode=0, rd_empty=0 always, wr_full=0. Expect:
  - 16 wr_en pulses with wr_data equal to the input sequence;
  - with FIFO_DEPTH=8 and PIPE_STAGES=2, a sustained 1 line/cycle;
  - first wr_en 2 cycles after the first rd_en;
  - done=1 the cycle after the 16th write; lines_done=16.
- Add with wrap: mode=1, operand=0x00000001, lanes 0xFFFFFFFF → lanes 0x00000000 with no carry into neighbouring lanes. Same lanes with mode=2 and operand=0xFFFF0000 → 0x0000FFFF.
- Byte-reverse: mode=3, lane 0x11223344 → 0x44332211 in every lane, size=1. Then done=1 and busy=0.
- Back-pressure: size=32, wr_full held 1 for 20 cycles. Expect:
  - rd_en stops after exactly FIFO_DEPTH lines;
  - no line is lost;
  - after release, all 32 lines arrive in order; randomised rd_empty/wr_full gives the same result.
- Edge cases:
  - size=0 go → done next cycle with no rd_en/wr_en;
  - go during RUN has no effect;
  - rst pulled low at line 5 of 10 → all outputs 0 immediately; after release a new job of size=3 completes cleanly.
